// File: rtl/spi_pkg.sv
// Shared state encoding, control-register field map and fill constants
// for the SPI buffer-transfer controller.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SEND  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_STORE = 3'd4,
    ST_DONE  = 3'd5
  } spi_state_t;

  localparam int SEND_BIT = 0;
  localparam int ALL1_BIT = 2;
  localparam int ALL0_BIT = 3;
  localparam int NTX_LSB  = 4;
  localparam int NTX_W    = 9;
  localparam int NRX_LSB  = 16;
  localparam int NRX_W    = 9;
  localparam int CNT_W    = 9;

  localparam logic [7:0] FILL_ONES  = 8'hFF;
  localparam logic [7:0] FILL_ZEROS = 8'h00;

endpackage

// File: rtl/spi_tx_sel.sv
// Combinational source select for the outgoing byte: fill-ones beats
// fill-zeros, which beats buffer data. Zero latency, no flow control.
module spi_tx_sel
  import spi_pkg::*;
(
  input  logic       all_1s,
  input  logic       all_0s,
  input  logic [7:0] buf_byte,
  output logic [7:0] tx_byte
);

  always_comb begin
    tx_byte = buf_byte;
    if (all_1s) begin
      tx_byte = FILL_ONES;
    end else if (all_0s) begin
      tx_byte = FILL_ZEROS;
    end
  end

endmodule

// File: rtl/spi_ctrl_fsm.sv
// Drives a byte shifter from a data buffer, storing received bytes back in place.
// Per byte: LOAD, SEND, WAIT (until done_i), STORE; the shifter paces the transfer.
module spi_ctrl_fsm
  import spi_pkg::*;
#(
  parameter int BUF_AW = 5,
  parameter int CTRL_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic              ctrl_we_o,
  output logic [BUF_AW-1:0] buf_addr_o,
  input  logic [7:0]        buf_rdata_i,
  output logic [7:0]        buf_wdata_o,
  output logic              buf_we_o,
  output logic [7:0]        tx_byte_o,
  output logic              start_o,
  input  logic              done_i,
  input  logic [7:0]        rx_byte_i,
  output logic              cs_o,
  output logic              busy_o
);

  spi_state_t        state, state_nxt;
  logic [CNT_W-1:0]  n, n_nxt, n_end;
  logic              all_1s_q, all_0s_q;
  logic [7:0]        rx_q, tx_q, tx_sel;
  logic              accept;

  logic              start_c, buf_we_c, ctrl_we_c;
  logic [BUF_AW-1:0] buf_addr_c;
  logic [7:0]        buf_wdata_c, tx_byte_c;
  logic [CTRL_W-1:0] ctrl_c;

  assign accept = (state == ST_IDLE) && ctrl_i[SEND_BIT];

  spi_tx_sel u_tx_sel (
    .all_1s   (all_1s_q),
    .all_0s   (all_0s_q),
    .buf_byte (buf_rdata_i),
    .tx_byte  (tx_sel)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= ST_IDLE;
      n        <= '0;
      n_end    <= '0;
      all_1s_q <= 1'b0;
      all_0s_q <= 1'b0;
      rx_q     <= '0;
      tx_q     <= '0;
    end else begin
      state <= state_nxt;
      n     <= n_nxt;
      // Transfer parameters are frozen at start so CPU edits mid-burst are harmless
      if (accept) begin
        n_end    <= ctrl_i[NTX_LSB +: NTX_W];
        all_1s_q <= ctrl_i[ALL1_BIT];
        all_0s_q <= ctrl_i[ALL0_BIT];
      end
      if (state == ST_SEND) begin
        tx_q <= tx_sel;
      end
      if (state == ST_WAIT && done_i) begin
        rx_q <= rx_byte_i;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    n_nxt       = n;
    start_c     = 1'b0;
    buf_we_c    = 1'b0;
    ctrl_we_c   = 1'b0;
    buf_addr_c  = '0;
    buf_wdata_c = '0;
    ctrl_c      = '0;
    tx_byte_c   = tx_q;

    case (state)
      ST_IDLE: begin
        if (accept) begin
          n_nxt     = '0;
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        buf_addr_c = n[BUF_AW-1:0];
        state_nxt  = ST_SEND;
      end
      ST_SEND: begin
        // Read data from LOAD's address is valid now; tx_q holds it afterwards
        buf_addr_c = n[BUF_AW-1:0];
        start_c    = 1'b1;
        tx_byte_c  = tx_sel;
        state_nxt  = ST_WAIT;
      end
      ST_WAIT: begin
        buf_addr_c = n[BUF_AW-1:0];
        if (done_i) begin
          state_nxt = ST_STORE;
        end
      end
      ST_STORE: begin
        buf_addr_c                  = n[BUF_AW-1:0];
        buf_we_c                    = 1'b1;
        buf_wdata_c                 = rx_q;
        ctrl_we_c                   = 1'b1;
        ctrl_c                      = ctrl_i;
        ctrl_c[NRX_LSB +: NRX_W]    = n + CNT_W'(1);
        if (n == n_end) begin
          state_nxt = ST_DONE;
        end else begin
          n_nxt     = n + CNT_W'(1);
          state_nxt = ST_LOAD;
        end
      end
      ST_DONE: begin
        ctrl_we_c        = 1'b1;
        ctrl_c           = ctrl_i;
        ctrl_c[SEND_BIT] = 1'b0;
        state_nxt        = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Reset masks every strobe immediately, so an abort cannot leak a write
  assign start_o     = start_c   & ~rst_i;
  assign buf_we_o    = buf_we_c  & ~rst_i;
  assign ctrl_we_o   = ctrl_we_c & ~rst_i;
  assign buf_addr_o  = rst_i ? '0 : buf_addr_c;
  assign buf_wdata_o = rst_i ? '0 : buf_wdata_c;
  assign ctrl_o      = rst_i ? '0 : ctrl_c;
  assign tx_byte_o   = rst_i ? '0 : tx_byte_c;
  assign cs_o        = rst_i | (state == ST_IDLE);
  assign busy_o      = ~rst_i & (state != ST_IDLE);

endmodule

// File: tb/tb_spi_ctrl_fsm.sv
// Scoreboard bench for spi_ctrl_fsm: buffer, control register and shifter are
// modelled here; expected bytes, buffer writes and write-backs are queued per transfer.
module tb_spi_ctrl_fsm;

  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;
  localparam int CW    = 32;

  logic           clk = 1'b0;
  logic           rst_i;
  logic [CW-1:0]  ctrl_reg;
  logic [CW-1:0]  ctrl_o;
  logic           ctrl_we_o;
  logic [AW-1:0]  buf_addr_o;
  logic [7:0]     buf_rdata;
  logic [7:0]     buf_wdata_o;
  logic           buf_we_o;
  logic [7:0]     tx_byte_o;
  logic           start_o;
  logic           done_i;
  logic [7:0]     rx_byte_i;
  logic           cs_o;
  logic           busy_o;

  always #5 clk = ~clk;

  spi_ctrl_fsm #(.BUF_AW(AW), .CTRL_W(CW)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .ctrl_i      (ctrl_reg),
    .ctrl_o      (ctrl_o),
    .ctrl_we_o   (ctrl_we_o),
    .buf_addr_o  (buf_addr_o),
    .buf_rdata_i (buf_rdata),
    .buf_wdata_o (buf_wdata_o),
    .buf_we_o    (buf_we_o),
    .tx_byte_o   (tx_byte_o),
    .start_o     (start_o),
    .done_i      (done_i),
    .rx_byte_i   (rx_byte_i),
    .cs_o        (cs_o),
    .busy_o      (busy_o)
  );

  typedef struct packed { logic [AW-1:0] a; logic [7:0] d; } bw_t;
  typedef struct packed { logic done; logic [8:0] nrx; } cw_t;

  int          tests = 0;
  int          fails = 0;
  int          cs_cnt = 0;
  int          n_start = 0;
  logic [7:0]  mem [DEPTH];
  logic [7:0]  mdl [DEPTH];
  logic [7:0]  exp_tx [$];
  bw_t         exp_bw [$];
  cw_t         exp_cw [$];
  logic [7:0]  cur_tx;
  logic        tb_we;
  logic [AW-1:0] tb_addr;
  logic [7:0]  tb_data;
  logic        cpu_we;
  logic [CW-1:0] cpu_data;
  int          sh_d;
  logic [7:0]  sh_key;
  logic        sh_glitch;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Buffer with synchronous 1-cycle read and a bench-side preload port
  always @(posedge clk) begin
    if (buf_we_o) mem[buf_addr_o] <= buf_wdata_o;
    else if (tb_we) mem[tb_addr] <= tb_data;
    buf_rdata <= mem[buf_addr_o];
  end

  // Control register: the controller's write-back wins over the CPU
  always @(posedge clk) begin
    if (ctrl_we_o) ctrl_reg <= ctrl_o;
    else if (cpu_we) ctrl_reg <= cpu_data;
  end

  // Shifter: done sh_d cycles after start, answers tx ^ key; optional stray pulse in STORE
  initial begin
    logic [7:0] sh_tx;
    done_i = 1'b0;
    rx_byte_i = 8'h00;
    forever begin
      @(negedge clk);
      if (start_o && !rst_i) begin
        sh_tx = tx_byte_o;
        repeat (sh_d) @(negedge clk);
        if (busy_o) check("tx_hold", 32'(tx_byte_o), 32'(cur_tx));
        done_i = 1'b1;
        rx_byte_i = sh_tx ^ sh_key;
        @(negedge clk);
        done_i = 1'b0;
        rx_byte_i = 8'($urandom);
        if (sh_glitch) begin
          done_i = 1'b1;
          @(negedge clk);
          done_i = 1'b0;
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a strobe
  initial begin
    bw_t b;
    cw_t c;
    logic [CW-1:0] e;
    forever begin
      @(negedge clk);
      if (!rst_i) begin
        if (cs_o == 1'b0) cs_cnt++;
        if (start_o) begin
          n_start++;
          if (exp_tx.size() == 0) check("unexpected_start", 32'd1, 32'd0);
          else begin
            cur_tx = exp_tx.pop_front();
            check("tx_byte", 32'(tx_byte_o), 32'(cur_tx));
          end
        end
        if (buf_we_o) begin
          if (exp_bw.size() == 0) check("unexpected_buf_we", 32'd1, 32'd0);
          else begin
            b = exp_bw.pop_front();
            check("buf_addr", 32'(buf_addr_o), 32'(b.a));
            check("buf_wdata", 32'(buf_wdata_o), 32'(b.d));
          end
        end
        if (ctrl_we_o) begin
          if (exp_cw.size() == 0) check("unexpected_ctrl_we", 32'd1, 32'd0);
          else begin
            c = exp_cw.pop_front();
            e = ctrl_reg;
            if (c.done) e[0] = 1'b0;
            else e[24:16] = c.nrx;
            check(c.done ? "ctrl_done" : "ctrl_nrx", ctrl_o, e);
          end
        end
      end
    end
  end

  task automatic preload(input int a, input logic [7:0] v);
    @(negedge clk);
    tb_we = 1'b1;
    tb_addr = AW'(a);
    tb_data = v;
    mdl[a] = v;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  task automatic start_xfer(input logic [8:0] nend, input bit a1, input bit a0, input int d,
                            input logic [7:0] key, input bit glitch, output logic [CW-1:0] w);
    bw_t b;
    cw_t c;
    logic [7:0] tx;
    int a;
    sh_d = d;
    sh_key = key;
    sh_glitch = glitch;
    for (int k = 0; k <= int'(nend); k++) begin
      a = k % DEPTH;
      tx = a1 ? 8'hFF : (a0 ? 8'h00 : mdl[a]);
      exp_tx.push_back(tx);
      b.a = AW'(a);
      b.d = tx ^ key;
      exp_bw.push_back(b);
      mdl[a] = tx ^ key;
      c.done = 1'b0;
      c.nrx = 9'(k + 1);
      exp_cw.push_back(c);
    end
    c.done = 1'b1;
    c.nrx = 9'd0;
    exp_cw.push_back(c);
    w = $urandom;
    w[0] = 1'b1;
    w[2] = a1;
    w[3] = a0;
    w[12:4] = nend;
    @(negedge clk);
    cpu_data = w;
    cpu_we = 1'b1;
    @(negedge clk);
    cpu_we = 1'b0;
  endtask

  task automatic run_xfer(input logic [8:0] nend, input bit a1, input bit a0, input int d,
                          input logic [7:0] key, input bit glitch, input bit mid);
    logic [CW-1:0] w;
    int cs0, st0, cyc, budget, nb;
    bit mid_done;
    cs0 = cs_cnt;
    st0 = n_start;
    nb = int'(nend) + 1;
    start_xfer(nend, a1, a0, d, key, glitch, w);
    budget = nb * (d + 6) + 20;
    cyc = 0;
    mid_done = !mid;
    while (!busy_o && cyc < 10) begin @(negedge clk); cyc++; end
    while (busy_o && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (!mid_done && n_start != st0) begin
        @(negedge clk);
        cpu_data = ctrl_reg;
        cpu_data[0] = 1'b1;
        cpu_data[12:4] = 9'd9;
        cpu_we = 1'b1;
        @(negedge clk);
        cpu_we = 1'b0;
        mid_done = 1'b1;
      end
    end
    check("xfer_finished", 32'(busy_o), 32'd0);
    check("cs_low_cycles", 32'(cs_cnt - cs0), 32'(nb * (d + 3) + 1));
    check("start_pulses", 32'(n_start - st0), 32'(nb));
    check("final_send", 32'(ctrl_reg[0]), 32'd0);
    check("final_nrx", 32'(ctrl_reg[24:16]), 32'(nb));
    check("final_ntx_end", 32'(ctrl_reg[12:4]), mid ? 32'd9 : 32'(nend));
    check("passthrough", ctrl_reg & 32'hFE00_E002, w & 32'hFE00_E002);
    for (int i = 0; i < DEPTH; i++) check("buffer", 32'(mem[i]), 32'(mdl[i]));
    check("queues_drained", 32'(exp_tx.size() + exp_bw.size() + exp_cw.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [CW-1:0] w;
    logic [7:0] pre [DEPTH];
    logic [7:0] key;
    int st0, cyc;
    rst_i = 1'b1;
    cpu_we = 1'b1;
    cpu_data = '0;
    tb_we = 1'b0;
    tb_addr = '0;
    tb_data = '0;
    sh_d = 4;
    sh_key = 8'h00;
    sh_glitch = 1'b0;
    cur_tx = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_cs", 32'(cs_o), 32'd1);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_strobes", 32'({start_o, buf_we_o, ctrl_we_o}), 32'd0);
    check("rst_data", 32'({tx_byte_o, buf_wdata_o, 6'(buf_addr_o)}), 32'd0);
    check("rst_ctrl_o", ctrl_o, 32'd0);
    rst_i = 1'b0;
    cpu_we = 1'b0;
    @(negedge clk);
    check("idle_cs", 32'(cs_o), 32'd1);
    check("idle_busy", 32'(busy_o), 32'd0);
    for (int i = 0; i < DEPTH; i++) preload(i, 8'($urandom));

    // Single byte: A5 out, 3C back after 8 cycles
    preload(0, 8'hA5);
    run_xfer(9'd0, 1'b0, 1'b0, 8, 8'h99, 1'b0, 1'b0);
    check("single_buf0", 32'(mem[0]), 32'h3C);

    // Burst of four, echo inverted
    for (int i = 0; i < 4; i++) preload(i, 8'(i + 1));
    run_xfer(9'd3, 1'b0, 1'b0, 5, 8'hFF, 1'b1, 1'b0);
    check("burst_buf", {mem[0], mem[1], mem[2], mem[3]}, 32'hFEFD_FCFB);

    // Fill modes
    run_xfer(9'd2, 1'b1, 1'b1, 3, 8'($urandom), 1'b1, 1'b0);
    run_xfer(9'd3, 1'b0, 1'b1, 2, 8'($urandom), 1'b0, 1'b0);

    // Address wrap across a 4-entry buffer
    run_xfer(9'd5, 1'b0, 1'b0, 3, 8'($urandom), 1'b0, 1'b0);

    // CPU rewrites send/n_tx_end while busy
    run_xfer(9'd3, 1'b0, 1'b0, 6, 8'($urandom), 1'b0, 1'b1);

    // Reset in WAIT of the second of four bytes
    for (int i = 0; i < DEPTH; i++) pre[i] = mdl[i];
    key = 8'($urandom);
    st0 = n_start;
    start_xfer(9'd3, 1'b0, 1'b0, 8, key, 1'b0, w);
    cyc = 0;
    while (n_start - st0 < 2 && cyc < 200) begin @(negedge clk); cyc++; end
    check("rst_reach_byte2", 32'(n_start - st0), 32'd2);
    @(negedge clk);
    rst_i = 1'b1;
    cpu_data = ctrl_reg;
    cpu_data[0] = 1'b0;
    cpu_we = 1'b1;
    #1;
    check("abort_cs", 32'(cs_o), 32'd1);
    check("abort_strobes", 32'({busy_o, start_o, buf_we_o, ctrl_we_o}), 32'd0);
    @(negedge clk);
    rst_i = 1'b0;
    cpu_we = 1'b0;
    exp_tx.delete();
    exp_bw.delete();
    exp_cw.delete();
    check("abort_idle_busy", 32'(busy_o), 32'd0);
    check("abort_idle_cs", 32'(cs_o), 32'd1);
    for (int i = 0; i < DEPTH; i++) mdl[i] = pre[i];
    mdl[0] = pre[0] ^ key;
    repeat (20) @(negedge clk);
    check("late_done_ignored", 32'(busy_o), 32'd0);
    check("abort_starts", 32'(n_start - st0), 32'd2);
    check("abort_nrx", 32'(ctrl_reg[24:16]), 32'd1);
    for (int i = 0; i < DEPTH; i++) check("abort_buffer", 32'(mem[i]), 32'(mdl[i]));

    // Randomized transfers
    for (int t = 0; t < 8; t++) begin
      run_xfer(9'($urandom_range(0, 12)), ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
               int'($urandom_range(1, 6)), 8'($urandom), 1'($urandom), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
